// File: rtl/press_history_pkg.sv
// Shared constants and helpers for the press_history code-entry block.
package press_history_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  // Bits needed to hold a slot count from 0 up to and including depth.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/press_history_if.sv
// Button-press input channel for press_history.
interface press_history_if #(
  parameter int WIDTH = 4
);
  // press_valid high for one cycle delivers one press; there is no ready, the
  // block accepts every press it sees. press_code only matters while valid.
  logic             press_valid;
  logic [WIDTH-1:0] press_code;

  modport master (output press_valid, output press_code);
  modport slave  (input  press_valid, input  press_code);
endinterface

// File: rtl/press_history_reg_en.sv
// One history slot: register with load enable, synchronous clear and async reset.
module reg_en #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over a load so an entry that completes and auto-clears ends empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/press_history.sv
// Shift-register history of button presses, compared against a target combo
// each time an entry of DEPTH presses completes.
module press_history
  import press_history_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AUTO_CLEAR = 1,
  localparam int CW        = count_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  press_history_if.slave         press,
  input  logic [DEPTH*WIDTH-1:0] combo,
  output logic [DEPTH*WIDTH-1:0] history,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   match,
  output logic                   fail
);

  logic                   accept;
  logic                   complete;
  logic                   slot_clr;
  logic [CW-1:0]          post_count;
  logic [DEPTH*WIDTH-1:0] next_hist;

  always_comb begin
    accept     = press.press_valid && !clear;
    post_count = (count == CW'(DEPTH)) ? count : count + CW'(1);
    complete   = accept && (post_count == CW'(DEPTH));
    next_hist  = {history[(DEPTH-1)*WIDTH-1:0], press.press_code};
    slot_clr   = clear || (complete && (AUTO_CLEAR != 0));
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    reg_en #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (accept),
      .clr     (slot_clr),
      .d       (next_hist[i*WIDTH +: WIDTH]),
      .q       (history[i*WIDTH +: WIDTH])
    );
  end

  // Comparison uses the post-shift history, i.e. the entry as it completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      full  <= 1'b0;
      match <= 1'b0;
      fail  <= 1'b0;
    end else begin
      match <= complete && (next_hist == combo);
      fail  <= complete && (next_hist != combo);
      if (slot_clr) begin
        count <= '0;
        full  <= 1'b0;
      end else if (accept) begin
        count <= post_count;
        full  <= (post_count == CW'(DEPTH));
      end
    end
  end

endmodule

// File: tb/tb_press_history.sv
// Directed bench for press_history: one instance with auto-clear, one without.
module tb_press_history;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear_a = 1'b0;
  logic clear_b = 1'b0;
  logic [D*W-1:0] combo_a = '0;
  logic [D*W-1:0] combo_b = '0;

  logic [D*W-1:0] hist_a, hist_b;
  logic [CW-1:0]  cnt_a, cnt_b;
  logic           full_a, full_b, match_a, match_b, fail_a, fail_b;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  press_history_if #(.WIDTH(W)) if_a ();
  press_history_if #(.WIDTH(W)) if_b ();

  press_history #(.WIDTH(W), .DEPTH(D), .AUTO_CLEAR(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear_a), .press(if_a.slave),
    .combo(combo_a), .history(hist_a), .count(cnt_a), .full(full_a),
    .match(match_a), .fail(fail_a)
  );

  press_history #(.WIDTH(W), .DEPTH(D), .AUTO_CLEAR(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear_b), .press(if_b.slave),
    .combo(combo_b), .history(hist_b), .count(cnt_b), .full(full_b),
    .match(match_b), .fail(fail_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // drivers: each press occupies exactly one rising edge; results sampled #1 after it
  task automatic press_a(input logic [W-1:0] code);
    @(negedge clk);
    if_a.press_valid = 1'b1;
    if_a.press_code  = code;
    @(posedge clk);
    #1;
    if_a.press_valid = 1'b0;
  endtask

  task automatic press_b(input logic [W-1:0] code);
    @(negedge clk);
    if_b.press_valid = 1'b1;
    if_b.press_code  = code;
    @(posedge clk);
    #1;
    if_b.press_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] h, input logic [31:0] c,
                       input logic [31:0] m, input logic [31:0] f);
    check({tag, "_hist"},  32'(hist_a),  h);
    check({tag, "_count"}, 32'(cnt_a),   c);
    check({tag, "_match"}, 32'(match_a), m);
    check({tag, "_fail"},  32'(fail_a),  f);
  endtask

  initial begin
    if_a.press_valid = 1'b0; if_a.press_code = '0;
    if_b.press_valid = 1'b0; if_b.press_code = '0;
    #1;
    chk_a("reset", 32'h0, 32'h0, 32'h0, 32'h0);
    check("reset_full", 32'(full_a), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // correct combo, back to back; scoreboard holds expected histories
    combo_a = 16'h1234;
    combo_b = 16'h1234;
    exp_q = {32'h0001, 32'h0012, 32'h0123, 32'h0000};
    for (int i = 1; i <= 4; i++) begin
      press_a(W'(i));
      check("seq_hist", 32'(hist_a), exp_q.pop_front());
      check("seq_count", 32'(cnt_a), (i == 4) ? 32'd0 : 32'(i));
      check("seq_match", 32'(match_a), (i == 4) ? 32'd1 : 32'd0);
      check("seq_fail", 32'(fail_a), 32'd0);
      check("seq_full", 32'(full_a), 32'd0);
    end
    idle_cycle();
    chk_a("post_match", 32'h0, 32'h0, 32'h0, 32'h0);

    // wrong last digit
    press_a(4'h1); press_a(4'h2); press_a(4'h3); press_a(4'h5);
    chk_a("wrong", 32'h0, 32'h0, 32'h0, 32'h1);
    idle_cycle();
    check("wrong_fail_pulse", 32'(fail_a), 32'h0);

    // sliding window without auto-clear
    press_b(4'h9); press_b(4'h1); press_b(4'h2);
    check("win_count3", 32'(cnt_b), 32'd3);
    check("win_full3", 32'(full_b), 32'd0);
    press_b(4'h3);
    check("win4_hist", 32'(hist_b), 32'h9123);
    check("win4_count", 32'(cnt_b), 32'd4);
    check("win4_full", 32'(full_b), 32'd1);
    check("win4_fail", 32'(fail_b), 32'd1);
    check("win4_match", 32'(match_b), 32'd0);
    press_b(4'h4);
    check("win5_hist", 32'(hist_b), 32'h1234);
    check("win5_count", 32'(cnt_b), 32'd4);
    check("win5_match", 32'(match_b), 32'd1);
    check("win5_fail", 32'(fail_b), 32'd0);

    // clear beats a simultaneous press
    press_a(4'h1); press_a(4'h2);
    @(negedge clk);
    clear_a = 1'b1;
    if_a.press_valid = 1'b1;
    if_a.press_code  = 4'h3;
    @(posedge clk);
    #1;
    clear_a = 1'b0;
    if_a.press_valid = 1'b0;
    chk_a("clear", 32'h0, 32'h0, 32'h0, 32'h0);

    // async reset mid-entry, then a fresh entry
    press_a(4'h1); press_a(4'h2); press_a(4'h3);
    #2;
    reset_n = 1'b0;
    #1;
    chk_a("async_rst", 32'h0, 32'h0, 32'h0, 32'h0);
    check("async_rst_full_b", 32'(full_b), 32'h0);
    check("async_rst_count_b", 32'(cnt_b), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    press_a(4'h4);
    chk_a("after_rst", 32'h4, 32'h1, 32'h0, 32'h0);
    @(negedge clk);
    clear_a = 1'b1;
    @(posedge clk);
    #1;
    clear_a = 1'b0;

    // idle gaps between presses: state holds, same outcome
    for (int i = 1; i <= 4; i++) begin
      press_a(W'(i));
      exp_q.push_back((i == 4) ? 32'd0 : 32'(i));
      if (i < 4) begin
        for (int g = 0; g < 5; g++) begin
          idle_cycle();
          check("gap_count", 32'(cnt_a), exp_q[0]);
          check("gap_match", 32'(match_a), 32'd0);
        end
        void'(exp_q.pop_front());
      end
    end
    check("gap_final_count", 32'(cnt_a), exp_q.pop_front());
    check("gap_match_final", 32'(match_a), 32'd1);
    check("gap_fail_final", 32'(fail_a), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/press_history.md
PRESS_HISTORY -- requirements
Module: press_history

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the bits per button code.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of presses held; legal range 2..16.
REQ-003 The block SHALL have parameter AUTO_CLEAR, default 1; value 1 empties the history after each completed entry.
REQ-004 The block SHALL have a single clock and an asynchronous active-low reset, with ports as listed below.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 clear  in  1  synchronous clear of history and count.
REQ-008 press_valid  in  1  one press accepted per cycle while high.
REQ-009 press_code  in  WIDTH  code of the press; sampled only when press_valid=1.
REQ-010 combo  in  DEPTH*WIDTH  target sequence; slot 0 (LSBs) is the most recent press.
REQ-011 history  out  DEPTH*WIDTH  stored presses; slot 0 (LSBs) is the newest.
REQ-012 count  out  clog2(DEPTH+1)  number of valid slots, 0..DEPTH.
REQ-013 full  out  1  high when count==DEPTH.
REQ-014 match  out  1  registered one-cycle pulse: a completed entry equalled combo.
REQ-015 fail  out  1  registered one-cycle pulse: a completed entry differed from combo.

Function
REQ-016 An accepted press SHALL shift slot i into slot i+1, drop slot DEPTH-1 and load press_code into slot 0, all at one rising edge.
REQ-017 An accepted press SHALL increment count by 1, saturating at DEPTH.
REQ-018 A completed entry SHALL be an accepted press whose post-shift count equals DEPTH.
REQ-019 match SHALL be 1 in the cycle after a completed entry when the post-shift history equals combo bit-exactly; otherwise match SHALL be 0.
REQ-020 fail SHALL be 1 in the cycle after a completed entry when the post-shift history differs from combo; otherwise fail SHALL be 0.
REQ-021 match and fail SHALL never be 1 in the same cycle.
REQ-022 When AUTO_CLEAR=1, history and count SHALL be 0 after the completed-entry edge, with match/fail still reporting the comparison.
REQ-023 When AUTO_CLEAR=0 and full=1, each further press SHALL shift as a sliding window and SHALL count as a completed entry.
REQ-024 clear=1 SHALL zero history and count at the edge and suppress match/fail for that cycle, including when press_valid=1 in the same cycle (clear has priority).
REQ-025 With press_valid=0 and clear=0, all state SHALL hold and match/fail SHALL be 0 in the following cycle.
REQ-026 A change on combo SHALL affect only comparisons made at later edges.
REQ-027 Latency SHALL be 1 cycle from the press edge to history, count, full, match and fail.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately force history=0, count=0, full=0, match=0 and fail=0, independent of clk.
REQ-029 Reset asserted mid-entry SHALL discard partial presses, and no match/fail SHALL be generated for them.
REQ-030 After reset_n deasserts, the first accepted press SHALL be treated as press 1 of a new entry.

Structure
REQ-031 Package press_history_pkg SHALL hold the default WIDTH/DEPTH constants and the count-width function clog2(DEPTH+1).
REQ-032 Each history slot SHALL be an instance of the sub-module reg_en: a WIDTH-bit register with enable, synchronous clear, async active-low reset and non-blocking updates.
REQ-033 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Verification
REQ-034 Reset, then press 1,2,3,4 on consecutive cycles with combo=0x1234 -> count 1,2,3 then match=1 for one cycle; fail=0; count=0 afterwards (AUTO_CLEAR=1).
REQ-035 Press 1,2,3,5 with combo=0x1234 -> fail=1 for one cycle, match=0, history=0.
REQ-036 AUTO_CLEAR=0: press 9,1,2,3,4 with combo=0x1234 -> fail after the 4th press, match after the 5th, count stays 4.
REQ-037 Press 1,2 then clear=1 together with press_valid=1 (code 3) -> count=0, history=0, no pulses.
REQ-038 Press 1,2,3, assert reset_n=0 between clock edges -> outputs 0 immediately; then press 4 -> count=1, no match.
REQ-039 Idle gaps of 5 cycles between presses 1,2,3,4 -> same match result as back-to-back presses; state holds during the gaps.
